button_event_arbiter: RTL and testbench

//   Collects one-cycle debounced press pulses from N_BTN button debounce

---
 rtl/button_event_arbiter_pkg.sv | 16 +
 rtl/button_event_arbiter_rr_arbiter.sv | 39 +++
 rtl/button_event_arbiter.sv | 114 +++++++++++
 tb/tb_button_event_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_arbiter_pkg.sv
// Shared definitions for the button event arbiter.
//   - default sizing for the requester count, queue depth and id width
//   - button index constants for the ZedBoard push buttons
package button_event_arbiter_pkg;

   localparam int N_BTN_DEF      = 5;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam int ID_W_DEF       = 3;

   localparam int BTN_U = 0;
   localparam int BTN_D = 1;
   localparam int BTN_L = 2;
   localparam int BTN_R = 3;
   localparam int BTN_C = 4;

endpackage

// File: rtl/button_event_arbiter_rr_arbiter.sv
// Round-robin arbiter for the button event arbiter.
//   req   : pending request vector, bit i = button i
//   ptr   : index where the search starts; the search wraps N_BTN-1 -> 0
//   grant : one-hot grant, zero when req is zero
//   id    : encoded index of the granted bit, zero when nothing is granted
module rr_arbiter
   import button_event_arbiter_pkg::*;
#(
   parameter int N_BTN = N_BTN_DEF,
   parameter int ID_W  = ID_W_DEF
) (
   input  logic [N_BTN-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_BTN-1:0] grant,
   output logic [ID_W-1:0]  id
);

   always_comb begin
      logic            found;
      int              pos;
      logic [ID_W-1:0] idx;
      grant = '0;
      id    = '0;
      found = 1'b0;
      pos   = 0;
      idx   = '0;
      for (int i = 0; i < N_BTN; i++) begin
         pos = int'(ptr) + i;
         if (pos >= N_BTN) pos = pos - N_BTN;
         idx = ID_W'(pos);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            id         = idx;
         end
      end
   end

endmodule

// File: rtl/button_event_arbiter.sv
// Button event arbiter: merges one-clock press pulses from N_BTN debouncers
// into a single first-word-fall-through event queue.
//   clk, rst_n    : clock, asynchronous active-low reset
//   btn_pulse     : one-clock press pulses, bit i = button i
//   evt_valid     : queue head valid
//   evt_ready     : consumer accepts the head
//   evt_id        : button index of the head event (stale when evt_valid=0)
//   pending       : latched requests not yet written into the queue
//   fifo_level    : number of queued events, 0..FIFO_DEPTH
//   overflow      : sticky flag, a press was coalesced and therefore lost
//   clr_overflow  : synchronous clear of overflow (a new loss wins)
module button_event_arbiter
   import button_event_arbiter_pkg::*;
#(
   parameter int N_BTN      = N_BTN_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int ID_W       = ID_W_DEF
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [N_BTN-1:0]                btn_pulse,
   output logic                            evt_valid,
   input  logic                            evt_ready,
   output logic [ID_W-1:0]                 evt_id,
   output logic [N_BTN-1:0]                pending,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
   output logic                            overflow,
   input  logic                            clr_overflow
);

   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [N_BTN-1:0] pending_q, pending_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic             overflow_q, overflow_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ID_W-1:0]  mem_q [FIFO_DEPTH];

   logic [N_BTN-1:0] arb_grant;
   logic [ID_W-1:0]  arb_id;
   logic [N_BTN-1:0] grant;
   logic             room;
   logic             push;
   logic             pop;
   logic             lost;

   rr_arbiter #(
      .N_BTN (N_BTN),
      .ID_W  (ID_W)
   ) u_rr_arbiter (
      .req   (pending_q),
      .ptr   (ptr_q),
      .grant (arb_grant),
      .id    (arb_id)
   );

   always_comb begin
      // Space is judged on the registered level only, so a pop in the same
      // cycle never lets a grant through into a full queue.
      room       = (level_q != LVL_W'(FIFO_DEPTH));
      push       = room && (pending_q != '0);
      grant      = room ? arb_grant : '0;
      pop        = (level_q != '0) && evt_ready;

      // A press landing on a bit that stays pending collapses into the
      // existing request; a press on the bit granted now is a fresh request.
      pending_d  = (pending_q & ~grant) | btn_pulse;
      lost       = |(btn_pulse & pending_q & ~grant);
      overflow_d = lost ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);

      ptr_d = ptr_q;
      if (push) ptr_d = (arb_id == ID_W'(N_BTN - 1)) ? '0 : arb_id + 1'b1;

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q  <= '0;
         ptr_q      <= '0;
         overflow_q <= 1'b0;
         level_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         pending_q  <= pending_d;
         ptr_q      <= ptr_d;
         overflow_q <= overflow_d;
         level_q    <= level_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         if (push) mem_q[wr_ptr_q] <= arb_id;
      end
   end

   assign evt_valid  = (level_q != '0);
   assign evt_id     = mem_q[rd_ptr_q];
   assign pending    = pending_q;
   assign fifo_level = level_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
module tb_button_event_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] btn_pulse = '0;
   logic       evt_valid;
   logic       evt_ready = 1'b0;
   logic [2:0] evt_id;
   logic [4:0] pending;
   logic [2:0] fifo_level;
   logic       overflow;
   logic       clr_overflow = 1'b0;

   int vectors = 0;
   int errors  = 0;

   // reference model state
   int         m_q[$];
   logic [4:0] m_pend;
   int         m_ptr;
   logic       m_ovf;

   always #5 clk = ~clk;

   button_event_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_pulse    (btn_pulse),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_id       (evt_id),
      .pending      (pending),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      btn_pulse    = '0;
      evt_ready    = 1'b0;
      clr_overflow = 1'b0;
      rst_n        = 1'b0;
      #13;
      @(negedge clk);
      rst_n = 1'b1;
      m_q.delete();
      m_pend = '0;
      m_ptr  = 0;
      m_ovf  = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      int         g;
      int         j;
      logic [4:0] gmask;
      logic [4:0] lostv;
      g = -1;
      if (m_pend != 0 && m_q.size() < 4) begin
         for (int k = 0; k < 5; k++) begin
            j = (m_ptr + k) % 5;
            if (m_pend[j] && g < 0) g = j;
         end
      end
      gmask = (g >= 0) ? 5'(1 << g) : 5'd0;
      lostv = btn_pulse & m_pend & ~gmask;
      if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
      if (g >= 0) begin
         m_q.push_back(g);
         m_ptr = (g + 1) % 5;
      end
      m_pend = (m_pend & ~gmask) | btn_pulse;
      if (lostv != 0) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tick();
      vectors++;
      if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", evt_valid); end
      vectors++;
      if (pending !== 5'b0) begin errors++; $display("FAIL reset_pending got %b want 00000", pending); end
      vectors++;
      if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
      vectors++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
      vectors++;
      if (evt_id !== 3'd0) begin errors++; $display("FAIL reset_id got %0d want 0", evt_id); end
   endtask

   task automatic test_single_press();
      do_reset();
      evt_ready = 1'b1;
      btn_pulse = 5'b00100;
      tick();
      btn_pulse = '0;
      vectors++;
      if (pending !== 5'b00100 || evt_valid !== 1'b0) begin
         errors++; $display("FAIL single_pend got pend=%b valid=%b want 00100/0", pending, evt_valid);
      end
      tick();
      vectors++;
      if (evt_valid !== 1'b1 || evt_id !== 3'd2 || fifo_level !== 3'd1 || pending !== 5'b0) begin
         errors++; $display("FAIL single_head got v=%b id=%0d lvl=%0d pend=%b want 1/2/1/00000", evt_valid, evt_id, fifo_level, pending);
      end
      tick();
      vectors++;
      if (evt_valid !== 1'b0 || fifo_level !== 3'd0) begin
         errors++; $display("FAIL single_drain got v=%b lvl=%0d want 0/0", evt_valid, fifo_level);
      end
   endtask

   task automatic test_simultaneous();
      int exp_ids[4] = '{1, 2, 3, 4};
      do_reset();
      btn_pulse = 5'b11111;
      tick();
      btn_pulse = '0;
      repeat (4) tick();
      vectors++;
      if (fifo_level !== 3'd4 || pending !== 5'b10000 || evt_id !== 3'd0) begin
         errors++; $display("FAIL simul_full got lvl=%0d pend=%b id=%0d want 4/10000/0", fifo_level, pending, evt_id);
      end
      tick();
      vectors++;
      if (fifo_level !== 3'd4 || pending !== 5'b10000) begin
         errors++; $display("FAIL simul_hold got lvl=%0d pend=%b want 4/10000", fifo_level, pending);
      end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      vectors++;
      if (fifo_level !== 3'd3 || pending !== 5'b10000 || evt_id !== 3'd1) begin
         errors++; $display("FAIL simul_pop got lvl=%0d pend=%b id=%0d want 3/10000/1", fifo_level, pending, evt_id);
      end
      tick();
      vectors++;
      if (fifo_level !== 3'd4 || pending !== 5'b00000) begin
         errors++; $display("FAIL simul_id4 got lvl=%0d pend=%b want 4/00000", fifo_level, pending);
      end
      evt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (evt_valid !== 1'b1 || evt_id !== 3'(exp_ids[i])) begin
            errors++; $display("FAIL simul_order[%0d] got v=%b id=%0d want 1/%0d", i, evt_valid, evt_id, exp_ids[i]);
         end
         tick();
      end
      vectors++;
      if (evt_valid !== 1'b0) begin errors++; $display("FAIL simul_empty got v=%b want 0", evt_valid); end
   endtask

   task automatic test_fairness();
      do_reset();
      evt_ready = 1'b1;
      btn_pulse = 5'b01001;
      tick();
      for (int i = 0; i < 6; i++) begin
         tick();
         vectors++;
         if (evt_valid !== 1'b1 || evt_id !== ((i % 2 == 0) ? 3'd0 : 3'd3) || fifo_level !== 3'd1) begin
            errors++; $display("FAIL fair[%0d] got v=%b id=%0d lvl=%0d want 1/%0d/1", i, evt_valid, evt_id, fifo_level, (i % 2 == 0) ? 0 : 3);
         end
      end
      btn_pulse = '0;
   endtask

   task automatic test_overflow();
      do_reset();
      btn_pulse = 5'b11111;
      tick();
      btn_pulse = '0;
      repeat (4) tick();
      btn_pulse = 5'b00010;
      tick();
      vectors++;
      if (overflow !== 1'b0 || pending !== 5'b10010) begin
         errors++; $display("FAIL ovf_first got ovf=%b pend=%b want 0/10010", overflow, pending);
      end
      tick();
      btn_pulse = '0;
      vectors++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
      clr_overflow = 1'b1;
      tick();
      vectors++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", overflow); end
      btn_pulse = 5'b00010;
      tick();
      btn_pulse    = '0;
      clr_overflow = 1'b0;
      vectors++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_beats_clr got %b want 1", overflow); end
   endtask

   task automatic test_push_pop();
      do_reset();
      btn_pulse = 5'b00011;
      tick();
      btn_pulse = '0;
      tick();
      tick();
      btn_pulse = 5'b00100;
      tick();
      btn_pulse = '0;
      vectors++;
      if (fifo_level !== 3'd2 || evt_id !== 3'd0 || pending !== 5'b00100) begin
         errors++; $display("FAIL pp_setup got lvl=%0d id=%0d pend=%b want 2/0/00100", fifo_level, evt_id, pending);
      end
      evt_ready = 1'b1;
      tick();
      vectors++;
      if (fifo_level !== 3'd2 || evt_id !== 3'd1) begin
         errors++; $display("FAIL pp_same got lvl=%0d id=%0d want 2/1", fifo_level, evt_id);
      end
      tick();
      vectors++;
      if (fifo_level !== 3'd1 || evt_id !== 3'd2) begin
         errors++; $display("FAIL pp_next got lvl=%0d id=%0d want 1/2", fifo_level, evt_id);
      end
      tick();
      evt_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      btn_pulse = 5'b00111;
      tick();
      btn_pulse = 5'b01000;
      tick();
      btn_pulse = '0;
      tick();
      tick();
      vectors++;
      if (fifo_level !== 3'd3 || pending !== 5'b01000) begin
         errors++; $display("FAIL arst_setup got lvl=%0d pend=%b want 3/01000", fifo_level, pending);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (evt_valid !== 1'b0 || fifo_level !== 3'd0 || pending !== 5'b0 || overflow !== 1'b0 || evt_id !== 3'd0) begin
         errors++; $display("FAIL arst_clear got v=%b lvl=%0d pend=%b ovf=%b id=%0d want all 0", evt_valid, fifo_level, pending, overflow, evt_id);
      end
      @(negedge clk);
      rst_n = 1'b1;
      btn_pulse = 5'b10010;
      tick();
      btn_pulse = '0;
      tick();
      vectors++;
      if (evt_valid !== 1'b1 || evt_id !== 3'd1) begin
         errors++; $display("FAIL arst_fresh_ptr got v=%b id=%0d want 1/1", evt_valid, evt_id);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < 5; b++) btn_pulse[b] = ($urandom_range(0, 5) == 0);
         evt_ready    = ($urandom_range(0, 2) != 0);
         clr_overflow = ($urandom_range(0, 9) == 0);
         model_step();
         tick();
         vectors++;
         if (fifo_level !== 3'(m_q.size()) || evt_valid !== (m_q.size() != 0) || pending !== m_pend || overflow !== m_ovf) begin
            errors++;
            $display("FAIL rand[%0d] got lvl=%0d v=%b pend=%b ovf=%b want %0d/%b/%b/%b", c, fifo_level, evt_valid, pending, overflow, m_q.size(), m_q.size() != 0, m_pend, m_ovf);
         end
         if (m_q.size() != 0) begin
            vectors++;
            if (evt_id !== 3'(m_q[0])) begin
               errors++; $display("FAIL rand_id[%0d] got %0d want %0d", c, evt_id, m_q[0]);
            end
         end
      end
      btn_pulse    = '0;
      evt_ready    = 1'b0;
      clr_overflow = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_simultaneous();
      test_fairness();
      test_overflow();
      test_push_pop();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
